// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: op bit positions, op type and saturation limits shared by dsp_mac_pipe
package dsp_mac_pkg;
    localparam int OP_PRE_SUB = 0;
    localparam int OP_USE_PRE = 1;
    localparam int OP_ACC     = 2;
    localparam int OP_SUB     = 3;
    localparam int SAT_W      = 128;
    typedef logic [3:0] op_t;
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction
    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction
endpackage

// File: rtl/dsp_mac_acc_bank.sv
// dsp_mac_acc_bank: per-channel accumulators with one read/write point, bulk clear, wrap or clamp (DSP_MAC_SATURATE_EN)
module dsp_mac_acc_bank
    import dsp_mac_pkg::*;
#(
    parameter int P_WIDTH = 48,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [CH_W-1:0]    ch_i,
    input  logic               we_i,
    input  logic [P_WIDTH:0]   sum_i,
    output logic [P_WIDTH-1:0] rd_o,
    output logic [P_WIDTH-1:0] res_o,
    output logic               ovf_o
);
    logic [P_WIDTH-1:0] acc_q [NUM_CH];
    logic               ch_ok;

    assign ch_ok = 32'(ch_i) < NUM_CH;
    // a clear in the same cycle as an accumulate makes that accumulate start from zero
    assign rd_o  = ((en_i && clr_i) || !ch_ok) ? '0 : acc_q[ch_i];
    assign ovf_o = sum_i[P_WIDTH] ^ sum_i[P_WIDTH-1];
`ifdef DSP_MAC_SATURATE_EN
    localparam logic [SAT_W-1:0] MAX_V = sat_max(P_WIDTH);
    localparam logic [SAT_W-1:0] MIN_V = sat_min(P_WIDTH);
    assign res_o = ovf_o ? (sum_i[P_WIDTH] ? MIN_V[P_WIDTH-1:0] : MAX_V[P_WIDTH-1:0]) : sum_i[P_WIDTH-1:0];
`else
    assign res_o = sum_i[P_WIDTH-1:0];
`endif

    // clear first, then write, so a result landing with AccClr is kept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (en_i) begin
            if (clr_i) for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            if (we_i && ch_ok) acc_q[ch_i] <= res_o;
        end
    end
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: signed pre-add/multiply/accumulate pipeline with per-channel accumulators
// Define DSP_MAC_SATURATE_EN to clamp P and accumulators on overflow instead of wrapping.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int  A_WIDTH = 18,
    parameter int  B_WIDTH = 18,
    parameter int  P_WIDTH = 48,
    parameter int  NUM_CH  = 4,
    parameter int  MREG    = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               CE,
    input  logic               InValid,
    input  logic [CH_W-1:0]    Ch,
    input  logic [3:0]         Op,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [B_WIDTH-1:0] D,
    input  logic [P_WIDTH-1:0] C,
    input  logic               Carryin,
    input  logic               AccClr,
    output logic               OutValid,
    output logic [CH_W-1:0]    OutCh,
    output logic [P_WIDTH-1:0] P,
    output logic               Overflow
);
    localparam int PRE_W = B_WIDTH + 1;
    localparam int M_W   = A_WIDTH + B_WIDTH + 1;
    localparam int S_W   = P_WIDTH + 1;

    logic [A_WIDTH-1:0] a_q, a2_q;
    logic [B_WIDTH-1:0] b_q, d_q;
    logic [P_WIDTH-1:0] c_q, c2_q, c_s;
    op_t                op_q;
    logic [CH_W-1:0]    ch_q, ch2_q, ch_s, och_q;
    logic               ci_q, v_q, acc2_q, sub2_q, ci2_q, v2_q;
    logic               acc_s, sub_s, ci_s, v_s;
    logic [PRE_W-1:0]   pre_d, pre_q;
    logic [M_W-1:0]     m_d, m_s;
    logic [P_WIDTH-1:0] acc_rd, x_d, res_d, p_q;
    logic [S_W-1:0]     sum_d;
    logic               ovf_d, ovf_q, ov_q;

    // input register stage
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q  <= '0;
            b_q  <= '0;
            d_q  <= '0;
            c_q  <= '0;
            op_q <= '0;
            ch_q <= '0;
            ci_q <= 1'b0;
            v_q  <= 1'b0;
        end else if (CE) begin
            a_q  <= A;
            b_q  <= B;
            d_q  <= D;
            c_q  <= C;
            op_q <= Op;
            ch_q <= Ch;
            ci_q <= Carryin;
            v_q  <= InValid;
        end
    end

    assign pre_d = op_q[OP_USE_PRE]
                 ? (op_q[OP_PRE_SUB] ? {d_q[B_WIDTH-1], d_q} - {b_q[B_WIDTH-1], b_q}
                                     : {d_q[B_WIDTH-1], d_q} + {b_q[B_WIDTH-1], b_q})
                 : {b_q[B_WIDTH-1], b_q};

    // pre-adder register stage, one extra bit keeps the pre-add exact
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a2_q   <= '0;
            pre_q  <= '0;
            c2_q   <= '0;
            acc2_q <= 1'b0;
            sub2_q <= 1'b0;
            ch2_q  <= '0;
            ci2_q  <= 1'b0;
            v2_q   <= 1'b0;
        end else if (CE) begin
            a2_q   <= a_q;
            pre_q  <= pre_d;
            c2_q   <= c_q;
            acc2_q <= op_q[OP_ACC];
            sub2_q <= op_q[OP_SUB];
            ch2_q  <= ch_q;
            ci2_q  <= ci_q;
            v2_q   <= v_q;
        end
    end

    // full-width sign-extended operands make the truncated product the exact signed product
    assign m_d = {{(M_W-A_WIDTH){a2_q[A_WIDTH-1]}}, a2_q} * {{(M_W-PRE_W){pre_q[PRE_W-1]}}, pre_q};

    generate
        if (MREG != 0) begin : g_mreg
            logic [M_W-1:0]     m_q;
            logic [P_WIDTH-1:0] c3_q;
            logic [CH_W-1:0]    ch3_q;
            logic               acc3_q, sub3_q, ci3_q, v3_q;
            // optional product register stage
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    m_q    <= '0;
                    c3_q   <= '0;
                    ch3_q  <= '0;
                    acc3_q <= 1'b0;
                    sub3_q <= 1'b0;
                    ci3_q  <= 1'b0;
                    v3_q   <= 1'b0;
                end else if (CE) begin
                    m_q    <= m_d;
                    c3_q   <= c2_q;
                    ch3_q  <= ch2_q;
                    acc3_q <= acc2_q;
                    sub3_q <= sub2_q;
                    ci3_q  <= ci2_q;
                    v3_q   <= v2_q;
                end
            end
            assign m_s   = m_q;
            assign c_s   = c3_q;
            assign ch_s  = ch3_q;
            assign acc_s = acc3_q;
            assign sub_s = sub3_q;
            assign ci_s  = ci3_q;
            assign v_s   = v3_q;
        end else begin : g_nomreg
            assign m_s   = m_d;
            assign c_s   = c2_q;
            assign ch_s  = ch2_q;
            assign acc_s = acc2_q;
            assign sub_s = sub2_q;
            assign ci_s  = ci2_q;
            assign v_s   = v2_q;
        end
    endgenerate

    assign x_d   = acc_s ? acc_rd : c_s;
    assign sum_d = sub_s ? {x_d[P_WIDTH-1], x_d} - {{(S_W-M_W){m_s[M_W-1]}}, m_s} + {{P_WIDTH{1'b0}}, ci_s}
                         : {x_d[P_WIDTH-1], x_d} + {{(S_W-M_W){m_s[M_W-1]}}, m_s} + {{P_WIDTH{1'b0}}, ci_s};

    dsp_mac_acc_bank #(
        .P_WIDTH (P_WIDTH),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W)
    ) u_bank (
        .clk_i (Clk),
        .rst_i (Rst),
        .en_i  (CE),
        .clr_i (AccClr),
        .ch_i  (ch_s),
        .we_i  (v_s),
        .sum_i (sum_d),
        .rd_o  (acc_rd),
        .res_o (res_d),
        .ovf_o (ovf_d)
    );

    // result stage: OutValid pulses once per result and stays low while stalled
    always_ff @(posedge Clk) begin
        if (Rst) begin
            p_q   <= '0;
            och_q <= '0;
            ovf_q <= 1'b0;
            ov_q  <= 1'b0;
        end else if (CE) begin
            ov_q <= v_s;
            if (v_s) begin
                p_q   <= res_d;
                och_q <= ch_s;
                ovf_q <= ovf_d;
            end
        end else begin
            ov_q <= 1'b0;
        end
    end

    assign OutValid = ov_q;
    assign OutCh    = och_q;
    assign P        = p_q;
    assign Overflow = ovf_q;
endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised successor to the fixed-width DSP48A1 slice: a signed pre-add/multiply/accumulate pipeline with configurable operand widths, an optional multiplier register, a valid-tagged data path and a bank of per-channel accumulators for time-interleaved filters. It sits in the same datapath as the DSP48A1 and is used where several independent MAC channels share one multiplier.

## Interface
Parameters:
- A_WIDTH, 18, signed multiplier operand width
- B_WIDTH, 18, signed B and D width; pre-adder result is B_WIDTH+1 bits
- P_WIDTH, 48, accumulator/output width; must be >= A_WIDTH+B_WIDTH+1
- NUM_CH, 4, number of accumulator channels (>=1)
- MREG, 1, product register present (1) or bypassed (0)

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, synchronous, active-high
- CE  in  1  pipeline enable; 0 freezes every register except under Rst
- InValid  in  1  input sample valid
- Ch  in  max(1,$clog2(NUM_CH))  channel tag
- Op  in  4  [0] pre-add subtract (D−B) else D+B; [1] use pre-adder else B direct; [2] accumulate else load; [3] subtract product
- A  in  A_WIDTH  signed
- B, D  in  B_WIDTH  signed
- C  in  P_WIDTH  signed load operand
- Carryin  in  1  added at LSB of final sum
- AccClr  in  1  clear all accumulators (gated by CE)
- OutValid  out  1  result valid pulse
- OutCh  out  channel width  channel of P
- P  out  P_WIDTH  signed result
- Overflow  out  1  signed overflow of this result

## Operation
- S1: register A,B,D,C,Op,Ch,Carryin,InValid.
- S2: pre-add register: Op[1] ? (Op[0] ? D−B : D+B) : sign-extended B, B_WIDTH+1 bits, exact.
- S3: product M = A × preadd, A_WIDTH+B_WIDTH+1 bits, registered iff MREG=1.
- S4: X = Op[2] ? Acc[Ch] : C; Y = sign-extend(M) to P_WIDTH; Sum = Op[3] ? X − Y + Carryin : X + Y + Carryin, computed at P_WIDTH+1; Overflow = top two bits differ.
- S4 writes P, OutCh, Overflow and Acc[Ch] only when stage valid; bubbles leave P/Acc unchanged, OutValid=0.
- Single read/write point at S4: back-to-back same-channel accumulates see the just-written value, no hazard stall.
- AccClr with CE=1: all Acc cleared; a concurrent S4 accumulate reads 0 for its channel and its result is written.
- Rst: all pipeline regs, valids, Acc bank, P, OutCh, Overflow, OutValid -> 0; in-flight samples discarded. Rst overrides CE and AccClr.

## Timing
- Latency InValid -> OutValid: 3+MREG enabled cycles; throughput 1 sample/cycle.
- CE=0 for N cycles delays every in-flight result by exactly N cycles, values unchanged.
- Outputs registered; reset values all 0.

## Configuration
- DSP_MAC_SATURATE_EN defined: on Overflow, P and Acc[Ch] clamp to 2^(P_WIDTH−1)−1 (positive overflow) or −2^(P_WIDTH−1) (negative).
- Undefined: wrap modulo 2^P_WIDTH. Overflow flag identical in both builds.

## Structure
- Package dsp_mac_pkg: Op bit-index constants, op typedef, saturation max/min functions of P_WIDTH.
- Sub-module dsp_mac_acc_bank: NUM_CH×P_WIDTH register bank with read port, write-enable, AccClr, sat/wrap.

## Test plan
Defaults, MREG=1 unless stated.
- Load: A=3,B=5,D=7,C=10,Carryin=1,Op=0010,Ch=0 -> OutValid 4 cycles later, P=47; Op=0011 same data -> P=17.
- Accumulate: Ch=1 load Op=0000 C=0 A=2 B=3, then three Op=0100 back-to-back -> P=6,12,18,24 on consecutive cycles.
- Interleave: alternate Ch=0 (A=1,B=1) and Ch=2 (A=1,B=10) accumulates, 4 each after loads of 0 -> final 4 and 40; Op=1100 on Ch=2 -> 30.
- Overflow: load C=2^47−1, accumulate A=1,B=1 -> Overflow=1, P=−2^47 (wrap) / 2^47−1 (DSP_MAC_SATURATE_EN).
- Stall/MREG: CE low 3 cycles with 2 samples in flight -> OutValid shifted 3 cycles, same P; MREG=0 -> latency 3.
- Reset/clear: Rst mid-flight -> no OutValid, P=0, next accumulate A=1,B=1 gives 1; AccClr concurrent with accumulate (Acc=50, A=B=1) -> P=1, other channels 0.
